noise_channel: RTL and testbench
================================

# noise_channel

APU noise voice: a 15-bit LFSR clocked by a period-table timer, gated by a length counter and scaled by an envelope generator. It sits directly downstream of frame_counter: envelope steps on quarter_clk_en, length counter steps on half_clk_en. Its 4-bit output feeds the APU mixer, and its length-active flag feeds the $4015 status read.

## Interface
Parameters: none.

- clk  input  1  system clock
- rst_l  input  1  asynchronous, active-low reset
- cpu_clk_en  input  1  CPU-rate enable; register writes, timer and LFSR advance only when high
- apu_clk_en  input  1  APU-rate enable (every other cpu_clk_en); qualifies frame-counter strobes
- addr  input  16  CPU bus address
- data_in  input  8  CPU write data
- we  input  1  CPU write strobe
- quarter_clk_en  input  1  frame-counter quarter-frame strobe; one clk wide
- half_clk_en  input  1  frame-counter half-frame strobe; one clk wide
- out  output  4  channel sample, 0..15
- length_active  output  1  length counter nonzero (status bit 3 of $4015)

## Operation
- A register write is accepted when `we & cpu_clk_en` is high and addr matches:
  - $400C: halt_loop = d[5], const_vol = d[4], vol = d[3:0].
  - $400E: mode = d[7], period_idx = d[3:0].
  - $400F:
    - If enabled, length = LEN_TABLE[d[7:3]].
    - In all cases, set env_start.
  - $4015: enabled = d[3]. If d[3] is 0, length is cleared to 0 immediately.
- Timer, 12-bit, on cpu_clk_en:
  - If timer == 0: timer = NOISE_TABLE[period_idx] - 1 and the LFSR is clocked.
  - Otherwise timer decrements.
  - NOISE_TABLE = 4,8,16,32,64,96,128,160,202,254,380,508,762,1016,2034,4068.
  - Result: one LFSR step per table-value CPU cycles.
- LFSR, 15-bit, on each timer expiry:
  - fb = lfsr[0] ^ (mode ? lfsr[6] : lfsr[1]).
  - lfsr = {fb, lfsr[14:1]}.
- Envelope, on `quarter_clk_en & apu_clk_en`:
  - If env_start: clear env_start, decay = 15, divider = vol.
  - Else if divider == 0: divider = vol; if decay != 0, decrement decay; else if halt_loop, decay = 15.
  - Else divider decrements.
- Length counter, 8-bit, on `half_clk_en & apu_clk_en`: decrements if length != 0 and halt_loop is 0.
- LEN_TABLE[0..31] = 10,254,20,2,40,4,80,6,160,8,60,10,14,12,26,14,12,16,24,18,48,20,96,22,192,24,72,26,16,28,32,30.
- Output:
  - out = 0 if lfsr[0] == 1 or length == 0.
  - Otherwise out = const_vol ? vol : decay.
  - length_active = (length != 0).

## Timing
- Reset values:
  - lfsr = 15'h0001; timer = 0.
  - length = 0, decay = 0, divider = 0.
  - env_start = 0, enabled = 0.
  - All register fields = 0.
  - Hence out = 0 and length_active = 0 from reset.
- Register writes update state on the clk edge where `we & cpu_clk_en` is high. The new values are visible on out/length_active the next clk cycle (out and length_active are combinational from registered state).
- The timer reload uses the period_idx value in effect at the expiry edge. A $400E write does not restart the timer.
- Simultaneous events in one clk cycle:
  - $400F load and half-frame decrement: load wins; the decrement is discarded.
  - $4015 disable and half-frame decrement: length = 0.
  - $400F write and quarter-frame strobe: env_start is set; the quarter-frame sees the old env_start, and the new start is processed on the next quarter-frame.
  - $400F while enabled = 0: length stays 0, env_start is still set.
- Width and wrap rules:
  - Length never wraps below 0.
  - decay wraps 0 -> 15 only when halt_loop is set.
  - The timer is 12 bits (max reload 4067).
- The LFSR can never reach all-zero: it is seeded to 1 and the shift with XOR feedback preserves a nonzero state.
- Reset asserted mid-operation returns all state to reset values asynchronously. The first timer expiry after release is on the first cpu_clk_en.

## Test plan
- Reset, then $4015=08, $400C=1F (const vol 15, halt), $400E=00, $400F=08 (idx1):
  - length = 254 and length_active = 1.
  - LFSR steps every 4 cpu_clk_en.
  - out toggles 0/15 following ~lfsr[0].
- Length decay: $400C=0F, load idx 3 (length 2), issue 2 half strobes -> length_active falls to 0 and out = 0. A third strobe leaves length at 0.
- Envelope: $400C=02 (decay, vol 2, no loop), $400F write, quarter strobes:
  - First strobe: decay = 15.
  - Thereafter decay steps down every 3 strobes to 0 and holds.
  - With $400C=22 (loop), decay wraps 0 -> 15.
- Mode 1: $400E=80 from seed 1 -> LFSR sequence period 93 steps. Mode 0 -> period 32767 steps. Both are checked against a reference model.
- Disable: $4015=00 while length = 254 -> length_active = 0 next cycle. A subsequent $400F write leaves length at 0.
- Collision: $400F (idx1) written in the same cycle as half_clk_en with halt = 0 -> length = 254, not 253.

Source files
------------

// File: rtl/noise_channel.sv
// APU noise voice: LFSR clocked by a period-table timer, gated by a
// length counter and scaled by a decay envelope.
module noise_channel (
    input  logic        clk,
    input  logic        rst_l,
    input  logic        cpu_clk_en,
    input  logic        apu_clk_en,
    input  logic [15:0] addr,
    input  logic [7:0]  data_in,
    input  logic        we,
    input  logic        quarter_clk_en,
    input  logic        half_clk_en,
    output logic [3:0]  out,
    output logic        length_active
);

    function automatic logic [11:0] noise_period(input logic [3:0] idx);
        logic [11:0] p;
        case (idx)
            4'd0:    p = 12'd4;
            4'd1:    p = 12'd8;
            4'd2:    p = 12'd16;
            4'd3:    p = 12'd32;
            4'd4:    p = 12'd64;
            4'd5:    p = 12'd96;
            4'd6:    p = 12'd128;
            4'd7:    p = 12'd160;
            4'd8:    p = 12'd202;
            4'd9:    p = 12'd254;
            4'd10:   p = 12'd380;
            4'd11:   p = 12'd508;
            4'd12:   p = 12'd762;
            4'd13:   p = 12'd1016;
            4'd14:   p = 12'd2034;
            default: p = 12'd4068;
        endcase
        return p;
    endfunction

    function automatic logic [7:0] len_lookup(input logic [4:0] idx);
        logic [7:0] l;
        case (idx)
            5'd0:    l = 8'd10;
            5'd1:    l = 8'd254;
            5'd2:    l = 8'd20;
            5'd3:    l = 8'd2;
            5'd4:    l = 8'd40;
            5'd5:    l = 8'd4;
            5'd6:    l = 8'd80;
            5'd7:    l = 8'd6;
            5'd8:    l = 8'd160;
            5'd9:    l = 8'd8;
            5'd10:   l = 8'd60;
            5'd11:   l = 8'd10;
            5'd12:   l = 8'd14;
            5'd13:   l = 8'd12;
            5'd14:   l = 8'd26;
            5'd15:   l = 8'd14;
            5'd16:   l = 8'd12;
            5'd17:   l = 8'd16;
            5'd18:   l = 8'd24;
            5'd19:   l = 8'd18;
            5'd20:   l = 8'd48;
            5'd21:   l = 8'd20;
            5'd22:   l = 8'd96;
            5'd23:   l = 8'd22;
            5'd24:   l = 8'd192;
            5'd25:   l = 8'd24;
            5'd26:   l = 8'd72;
            5'd27:   l = 8'd26;
            5'd28:   l = 8'd16;
            5'd29:   l = 8'd28;
            5'd30:   l = 8'd32;
            default: l = 8'd30;
        endcase
        return l;
    endfunction

    logic        halt_loop;
    logic        const_vol;
    logic [3:0]  vol;
    logic        mode;
    logic [3:0]  period_idx;
    logic        enabled;
    logic [7:0]  length;
    logic        env_start;
    logic [3:0]  decay;
    logic [3:0]  divider;
    logic [11:0] timer;
    logic [14:0] lfsr;

    logic wr;
    logic wr_ctrl;
    logic wr_period;
    logic wr_len;
    logic wr_status;
    logic quarter;
    logic half;
    logic fb;

    assign wr        = we & cpu_clk_en;
    assign wr_ctrl   = wr & (addr == 16'h400C);
    assign wr_period = wr & (addr == 16'h400E);
    assign wr_len    = wr & (addr == 16'h400F);
    assign wr_status = wr & (addr == 16'h4015);
    assign quarter   = quarter_clk_en & apu_clk_en;
    assign half      = half_clk_en & apu_clk_en;
    assign fb        = lfsr[0] ^ (mode ? lfsr[6] : lfsr[1]);

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            halt_loop  <= 1'b0;
            const_vol  <= 1'b0;
            vol        <= 4'd0;
            mode       <= 1'b0;
            period_idx <= 4'd0;
            enabled    <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                halt_loop <= data_in[5];
                const_vol <= data_in[4];
                vol       <= data_in[3:0];
            end
            if (wr_period) begin
                mode       <= data_in[7];
                period_idx <= data_in[3:0];
            end
            if (wr_status)
                enabled <= data_in[3];
        end
    end

    // Reload uses the period_idx held at the expiry edge; a $400E write never restarts.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            timer <= 12'd0;
            lfsr  <= 15'h0001;
        end else if (cpu_clk_en) begin
            if (timer == 12'd0) begin
                timer <= noise_period(period_idx) - 12'd1;
                lfsr  <= {fb, lfsr[14:1]};
            end else begin
                timer <= timer - 12'd1;
            end
        end
    end

    // Disable beats load, load beats the half-frame decrement.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            length <= 8'd0;
        end else if (wr_status && !data_in[3]) begin
            length <= 8'd0;
        end else if (wr_len && enabled) begin
            length <= len_lookup(data_in[7:3]);
        end else if (half && length != 8'd0 && !halt_loop) begin
            length <= length - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            env_start <= 1'b0;
            decay     <= 4'd0;
            divider   <= 4'd0;
        end else begin
            if (wr_len)
                env_start <= 1'b1;
            else if (quarter && env_start)
                env_start <= 1'b0;
            if (quarter) begin
                if (env_start) begin
                    decay   <= 4'd15;
                    divider <= vol;
                end else if (divider == 4'd0) begin
                    divider <= vol;
                    if (decay != 4'd0)
                        decay <= decay - 4'd1;
                    else if (halt_loop)
                        decay <= 4'd15;
                end else begin
                    divider <= divider - 4'd1;
                end
            end
        end
    end

    assign length_active = (length != 8'd0);
    assign out = (lfsr[0] || length == 8'd0) ? 4'd0
               : (const_vol ? vol : decay);

endmodule

// File: tb/tb_noise_channel.sv
// Directed bench for noise_channel; LFSR/timer tracked by a reference
// model, length and envelope values hand-computed.
module tb_noise_channel;

    logic        clk = 1'b0;
    logic        rst_l;
    logic        cpu_clk_en;
    logic        apu_clk_en;
    logic [15:0] addr;
    logic [7:0]  data_in;
    logic        we;
    logic        quarter_clk_en;
    logic        half_clk_en;
    logic [3:0]  out;
    logic        length_active;

    int n_tests = 0;
    int n_fail  = 0;

    logic [14:0] m_lfsr;
    logic [11:0] m_timer;
    logic        m_mode;
    logic [3:0]  m_idx;
    int nt [16] = '{4, 8, 16, 32, 64, 96, 128, 160,
                    202, 254, 380, 508, 762, 1016, 2034, 4068};

    noise_channel dut (
        .clk            (clk),
        .rst_l          (rst_l),
        .cpu_clk_en     (cpu_clk_en),
        .apu_clk_en     (apu_clk_en),
        .addr           (addr),
        .data_in        (data_in),
        .we             (we),
        .quarter_clk_en (quarter_clk_en),
        .half_clk_en    (half_clk_en),
        .out            (out),
        .length_active  (length_active)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs,
                         input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_lfsr  = 15'h0001;
        m_timer = 12'd0;
        m_mode  = 1'b0;
        m_idx   = 4'd0;
    endtask

    // Drive one clk cycle from a negedge and return at the next negedge.
    task automatic step(input logic c, input logic a, input logic q,
                        input logic h, input logic w,
                        input logic [15:0] ad, input logic [7:0] d);
        logic fb;
        cpu_clk_en     = c;
        apu_clk_en     = a;
        quarter_clk_en = q;
        half_clk_en    = h;
        we             = w;
        addr           = ad;
        data_in        = d;
        @(posedge clk);
        if (c) begin
            if (m_timer == 12'd0) begin
                m_timer = 12'(nt[m_idx] - 1);
                fb = m_lfsr[0] ^ (m_mode ? m_lfsr[6] : m_lfsr[1]);
                m_lfsr = {fb, m_lfsr[14:1]};
            end else begin
                m_timer = m_timer - 12'd1;
            end
            if (w && ad == 16'h400E) begin
                m_mode = d[7];
                m_idx  = d[3:0];
            end
        end
        @(negedge clk);
        we             = 1'b0;
        quarter_clk_en = 1'b0;
        half_clk_en    = 1'b0;
        addr           = 16'h0000;
        data_in        = 8'h00;
    endtask

    task automatic wr(input logic [15:0] ad, input logic [7:0] d);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, ad, d);
    endtask

    task automatic idle();
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
    endtask

    task automatic qtr(input logic c, input logic a);
        step(c, a, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h00);
    endtask

    task automatic hlf(input logic a);
        step(1'b1, a, 1'b0, 1'b1, 1'b0, 16'h0000, 8'h00);
    endtask

    // Advance until lfsr[0]==0 and the next cpu cycle will not expire the timer.
    task automatic seek();
        for (int k = 0; k < 200; k++) begin
            if (m_lfsr[0] == 1'b0 && m_timer != 12'd0)
                break;
            idle();
        end
    endtask

    function automatic logic [7:0] exp_out(input logic [3:0] v);
        return m_lfsr[0] ? 8'd0 : {4'd0, v};
    endfunction

    initial begin
        int e;
        rst_l          = 1'b0;
        cpu_clk_en     = 1'b0;
        apu_clk_en     = 1'b0;
        addr           = 16'h0000;
        data_in        = 8'h00;
        we             = 1'b0;
        quarter_clk_en = 1'b0;
        half_clk_en    = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("rst_out", {4'd0, out}, 8'd0);
        check("rst_len", {7'd0, length_active}, 8'd0);
        rst_l = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
        check("post_rst_out", {4'd0, out}, 8'd0);
        check("post_rst_len", {7'd0, length_active}, 8'd0);

        // Mode 0, const volume 15, halt
        wr(16'h4015, 8'h08);
        wr(16'h400C, 8'h1F);
        wr(16'h400E, 8'h00);
        wr(16'h400F, 8'h08);
        check("load_len", {7'd0, length_active}, 8'd1);
        for (int i = 0; i < 1200; i++) begin
            idle();
            check("mode0_out", {4'd0, out}, exp_out(4'd15));
        end
        check("halt_len", {7'd0, length_active}, 8'd1);

        // Asynchronous reset mid-operation
        #2 rst_l = 1'b0;
        #1;
        check("async_rst_len", {7'd0, length_active}, 8'd0);
        check("async_rst_out", {4'd0, out}, 8'd0);
        model_reset();
        @(negedge clk);
        rst_l = 1'b1;

        // Mode 1 from seed 1
        wr(16'h4015, 8'h08);
        wr(16'h400C, 8'h1F);
        wr(16'h400E, 8'h80);
        wr(16'h400F, 8'h08);
        for (int i = 0; i < 800; i++) begin
            idle();
            check("mode1_out", {4'd0, out}, exp_out(4'd15));
        end

        // Length decay with halt clear
        wr(16'h400C, 8'h0F);
        wr(16'h400F, 8'h18);
        check("len2_active", {7'd0, length_active}, 8'd1);
        hlf(1'b1);
        check("len1_active", {7'd0, length_active}, 8'd1);
        hlf(1'b0);
        check("half_no_apu", {7'd0, length_active}, 8'd1);
        hlf(1'b1);
        check("len0_active", {7'd0, length_active}, 8'd0);
        check("len0_out", {4'd0, out}, 8'd0);
        hlf(1'b1);
        check("len0_hold", {7'd0, length_active}, 8'd0);

        // Load collides with half-frame: full 254 survives
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h400F, 8'h08);
        for (int i = 0; i < 253; i++)
            hlf(1'b1);
        check("coll_253", {7'd0, length_active}, 8'd1);
        hlf(1'b1);
        check("coll_254", {7'd0, length_active}, 8'd0);

        // Disable behaviour
        wr(16'h400F, 8'h08);
        check("dis_pre", {7'd0, length_active}, 8'd1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h4015, 8'h00);
        check("dis_no_cpu", {7'd0, length_active}, 8'd1);
        wr(16'h4015, 8'h00);
        check("dis_clear", {7'd0, length_active}, 8'd0);
        wr(16'h400F, 8'h08);
        check("dis_load", {7'd0, length_active}, 8'd0);
        wr(16'h4015, 8'h08);
        wr(16'h400F, 8'h08);
        check("reen_load", {7'd0, length_active}, 8'd1);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h4015, 8'h00);
        check("dis_half", {7'd0, length_active}, 8'd0);

        // Envelope decay, vol 2, no loop
        wr(16'h4015, 8'h08);
        wr(16'h400C, 8'h02);
        wr(16'h400F, 8'h08);
        seek();
        check("env_idle", {4'd0, out}, exp_out(4'd0));
        for (int k = 1; k <= 50; k++) begin
            qtr(1'b0, 1'b1);
            e = 15 - (k - 1) / 3;
            if (e < 0)
                e = 0;
            check("env_dec", {4'd0, out}, exp_out(4'(e)));
        end

        // Loop enabled: 0 wraps to 15
        seek();
        wr(16'h400C, 8'h22);
        check("loop_pre", {4'd0, out}, exp_out(4'd0));
        qtr(1'b0, 1'b1);
        check("loop_k51", {4'd0, out}, exp_out(4'd0));
        qtr(1'b0, 1'b1);
        check("loop_wrap", {4'd0, out}, exp_out(4'd15));
        qtr(1'b0, 1'b1);
        qtr(1'b0, 1'b1);
        check("loop_k54", {4'd0, out}, exp_out(4'd15));
        qtr(1'b0, 1'b1);
        check("loop_k55", {4'd0, out}, exp_out(4'd14));

        // $400F write collides with quarter-frame: start deferred
        seek();
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h400F, 8'h08);
        check("qcoll_old", {4'd0, out}, exp_out(4'd14));
        qtr(1'b0, 1'b0);
        check("q_no_apu", {4'd0, out}, exp_out(4'd14));
        qtr(1'b0, 1'b1);
        check("qcoll_start", {4'd0, out}, exp_out(4'd15));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
